bram_wght_sched: RTL and testbench
==================================

# bram_wght_sched

Single-clock scheduler that owns one weight BRAM: sequences its initial (or re-)load from a streaming source, then shares the read port among `NUM_REQ` neuron-core requesters with round-robin arbitration. Sits between the weight loader / neuron cores and a `bram_wght`-style memory, driving its read and write ports directly. Returns read data tagged with the requester ID, one cycle after grant.

## Interface
- `BIT_WIDTH`, 31, MSB index of a weight word (word width = BIT_WIDTH+1)
- `RAM_DEPTH`, 32, words in the BRAM
- `RAM_ADDR_WIDTH`, $clog2(RAM_DEPTH), address width
- `NUM_REQ`, 4, number of read requesters (≥2)
- `ID_W`, $clog2(NUM_REQ), requester ID width

- `clk`  in  1  sole clock; all logic on posedge
- `rst`  in  1  asynchronous, active-low reset
- `start_load`  in  1  pulse: begin a load phase
- `ld_valid`  in  1  loader word valid
- `ld_ready`  out  1  scheduler accepts loader word
- `ld_data`  in  BIT_WIDTH+1  loader word
- `load_done`  out  1  one-cycle pulse after last word written
- `sched_ready`  out  1  high in RUN
- `req`  in  NUM_REQ  per-requester read request (held until granted)
- `req_addr`  in  NUM_REQ*RAM_ADDR_WIDTH  packed addresses, requester i at slice i
- `gnt`  out  NUM_REQ  one-hot grant, same cycle as issue
- `rsp_valid`  out  1  read data valid
- `rsp_id`  out  ID_W  requester owning `rsp_data`
- `rsp_data`  out  BIT_WIDTH+1  read word
- `bram_ren`, `bram_raddr`  out  1, RAM_ADDR_WIDTH  BRAM read port
- `bram_wren`, `bram_wraddr`, `bram_wrdat`  out  1, RAM_ADDR_WIDTH, BIT_WIDTH+1  BRAM write port
- `bram_rdat`  in  BIT_WIDTH+1  BRAM registered read data

## Operation
- States: IDLE (after reset), LOAD, RUN.
- IDLE: `ld_ready`=0, `gnt`=0. `start_load` → LOAD, write counter cleared to 0.
- LOAD: `ld_ready`=1. On `ld_valid&&ld_ready`: `bram_wren`=1, `bram_wraddr`=counter, `bram_wrdat`=`ld_data`, counter+1. Write is combinational from handshake. Handshake at counter=RAM_DEPTH-1 → RUN next cycle, `load_done` pulses that same next cycle. `start_load` ignored in LOAD. No grants in LOAD.
- RUN: round-robin over `req`; search starts at (last granted index + 1) mod NUM_REQ; pointer is 0 after reset. At most one grant per cycle; `bram_ren`=|gnt, `bram_raddr`=`req_addr` slice of granted index. Requester drops `req` or presents next address after seeing `gnt`.
- `start_load` in RUN → LOAD next cycle; that cycle issues no grant (start_load wins over req). RR pointer preserved across reloads.
- Response pipeline independent of state: a grant issued in cycle t yields `rsp_valid`=1, `rsp_id`=registered index, `rsp_data`=`bram_rdat` in t+1, even if state changed to LOAD.
- No read/write address collision possible: reads and writes never overlap in a cycle.

## Timing
- Reset values: state IDLE, counter 0, RR pointer 0, `rsp_valid`=0, `rsp_id`=0, `load_done`=0; combinational outputs (`ld_ready`, `gnt`, `bram_ren`, `bram_wren`, `sched_ready`) 0 in IDLE; `rsp_data` follows `bram_rdat`.
- Grant→response latency: exactly 1 cycle; throughput 1 read/cycle.
- Load: RAM_DEPTH handshakes; `ld_valid` gaps stall counter without penalty.
- Counter wraps only implicitly: terminal handshake moves to RUN, counter cleared on next `start_load`.
- Reset mid-operation (any state): asynchronous return to IDLE; in-flight response discarded (`rsp_valid`=0); partial load not resumed.

## Structure
- Package `wght_sched_pkg`: state enum `sched_state_e` {IDLE, LOAD, RUN}.
- Sub-module `rr_arbiter` (params NUM_REQ): `req`, `en`, returns one-hot `gnt` and index; owns the RR pointer, updates only when a grant issues.
- Top holds FSM, write counter, response registers, address mux.

## Test plan
- Reset asserted mid-cycle → all registered outputs 0 immediately, `ld_ready`=0, `gnt`=0 with `req`=4'b1111.
- `start_load`, 32 words 0x100+i with random `ld_valid` gaps → writes at addr 0..31 in order, `load_done` single pulse the cycle `sched_ready` rises.
- RUN, `req`=4'b1111 held, addresses 3,7,11,15 → `gnt` 0001,0010,0100,1000,0001; `rsp_id` 0,1,2,3 one cycle later with `rsp_data` 0x103,0x107,0x10B,0x10F.
- Only requester 2 requesting continuously → `gnt`=0100 every cycle, back-to-back `rsp_valid`.
- Grant to requester 1 at t, `start_load` at t+1 with `req`=1111 → no grant at t+1, `rsp_valid` with id 1 at t+1, state LOAD at t+2.
- Reset during LOAD after 10 words → IDLE, subsequent `start_load` rewrites from addr 0.

Source files
------------

// File: rtl/bram_wght_sched_pkg.sv
// Shared types for the weight-BRAM scheduler.
package wght_sched_pkg;

  // Scheduler phases: idle after reset, loading weights, serving reads.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

endpackage : wght_sched_pkg

// File: rtl/bram_wght_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus binary index. The pointer holds the
// index where the next search starts and only moves when a grant issues.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx
);

  localparam int CW = ID_W + 1;

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_found;
  logic [CW-1:0]      w_cand;
  logic [ID_W-1:0]    w_ptr_nxt;

  // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_ptr} + CW'(i);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end else begin
        w_cand = w_cand;
      end
      if (i_en && !w_found && i_req[w_cand[ID_W-1:0]]) begin
        w_found                   = 1'b1;
        w_idx                     = w_cand[ID_W-1:0];
        w_gnt[w_cand[ID_W-1:0]]   = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next search starts just past the requester granted this cycle.
  always_comb begin
    if (w_idx == ID_W'(NUM_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_idx + ID_W'(1);
    end
  end

  // Advance the pointer only on an issued grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;

endmodule : rr_arbiter

// File: rtl/bram_wght_sched.sv
// Weight BRAM scheduler: streams the initial/re-load into the BRAM, then
// shares the read port among NUM_REQ requesters with round-robin grants.
// Read data comes back one cycle after the grant, tagged with the winner.
module bram_wght_sched #(
  parameter int BIT_WIDTH      = 31,
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_load,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [BIT_WIDTH:0]                ld_data,
  output logic                              load_done,
  output logic                              sched_ready,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]                gnt,
  output logic                              rsp_valid,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [BIT_WIDTH:0]                rsp_data,
  output logic                              bram_ren,
  output logic [RAM_ADDR_WIDTH-1:0]         bram_raddr,
  output logic                              bram_wren,
  output logic [RAM_ADDR_WIDTH-1:0]         bram_wraddr,
  output logic [BIT_WIDTH:0]                bram_wrdat,
  input  logic [BIT_WIDTH:0]                bram_rdat
);

  import wght_sched_pkg::*;

  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = RAM_ADDR_WIDTH'(RAM_DEPTH - 1);

  sched_state_e              r_state;
  logic [RAM_ADDR_WIDTH-1:0] r_wr_cnt;
  logic                      r_load_done;
  logic                      r_rsp_valid;
  logic [ID_W-1:0]           r_rsp_id;

  logic                      w_wr;
  logic                      w_arb_en;
  logic [NUM_REQ-1:0]        w_gnt;
  logic [ID_W-1:0]           w_idx;

  // A reload request in RUN pre-empts arbitration for that cycle.
  assign w_arb_en = (r_state == RUN) && !start_load;
  assign w_wr     = (r_state == LOAD) && ld_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_req   (req),
    .i_en    (w_arb_en),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx)
  );

  // Phase sequencing, write counter and the end-of-load pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wr_cnt    <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_load) begin
            r_state  <= LOAD;
            r_wr_cnt <= '0;
          end
        end
        LOAD: begin
          if (w_wr) begin
            if (r_wr_cnt == LAST_ADDR) begin
              r_state     <= RUN;
              r_load_done <= 1'b1;
            end else begin
              r_wr_cnt <= r_wr_cnt + RAM_ADDR_WIDTH'(1);
            end
          end
        end
        RUN: begin
          if (start_load) begin
            r_state  <= LOAD;
            r_wr_cnt <= '0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_wr_cnt <= '0;
        end
      endcase
    end
  end

  // Response tag pipeline; runs regardless of phase so a last grant still answers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_rsp_valid <= |w_gnt;
      if (|w_gnt) begin
        r_rsp_id <= w_idx;
      end else begin
        r_rsp_id <= r_rsp_id;
      end
    end
  end

  assign ld_ready    = (r_state == LOAD);
  assign sched_ready = (r_state == RUN);
  assign load_done   = r_load_done;

  assign gnt         = w_gnt;
  assign bram_ren    = |w_gnt;
  assign bram_raddr  = req_addr[w_idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];

  assign bram_wren   = w_wr;
  assign bram_wraddr = r_wr_cnt;
  assign bram_wrdat  = ld_data;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = bram_rdat;

endmodule : bram_wght_sched

// File: tb/tb_bram_wght_sched.sv
// Directed bench for bram_wght_sched with a registered-read BRAM model.
module tb_bram_wght_sched;

  logic        clk;
  logic        rst;
  logic        start_load;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        load_done;
  logic        sched_ready;
  logic [3:0]  req;
  logic [19:0] req_addr;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        bram_ren;
  logic [4:0]  bram_raddr;
  logic        bram_wren;
  logic [4:0]  bram_wraddr;
  logic [31:0] bram_wrdat;
  logic [31:0] bram_rdat;

  logic [31:0] mem [32];
  int total = 0;
  int bad   = 0;

  bram_wght_sched dut (
    .clk         (clk),
    .rst         (rst),
    .start_load  (start_load),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .load_done   (load_done),
    .sched_ready (sched_ready),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .bram_ren    (bram_ren),
    .bram_raddr  (bram_raddr),
    .bram_wren   (bram_wren),
    .bram_wraddr (bram_wraddr),
    .bram_wrdat  (bram_wrdat),
    .bram_rdat   (bram_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: synchronous write, registered read.
  always @(posedge clk) begin
    if (bram_wren) mem[bram_wraddr] <= bram_wrdat;
    if (bram_ren)  bram_rdat <= mem[bram_raddr];
  end

  task automatic test_reset;
    #3;
    total++; if (ld_ready !== 1'b0)    begin bad++; $display("FAIL rst_ld_ready got %b want 0", ld_ready); end
    total++; if (gnt !== 4'b0000)      begin bad++; $display("FAIL rst_gnt got %b want 0000", gnt); end
    total++; if (rsp_valid !== 1'b0)   begin bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    total++; if (rsp_id !== 2'd0)      begin bad++; $display("FAIL rst_rsp_id got %0d want 0", rsp_id); end
    total++; if (load_done !== 1'b0)   begin bad++; $display("FAIL rst_load_done got %b want 0", load_done); end
    total++; if (sched_ready !== 1'b0) begin bad++; $display("FAIL rst_sched_ready got %b want 0", sched_ready); end
    total++; if (bram_wren !== 1'b0 || bram_ren !== 1'b0) begin
      bad++; $display("FAIL rst_bram_en got wren=%b ren=%b want 0 0", bram_wren, bram_ren);
    end
    rst = 1'b1; req = 4'b0000; ld_valid = 1'b0;
  endtask

  // Feeds nwords with random valid gaps; optionally pulses start_load first.
  task automatic test_load(input logic [31:0] base, input int nwords, input bit do_start);
    int k = 0;
    int budget = 0;
    if (do_start) begin
      @(negedge clk); start_load = 1'b1; ld_valid = 1'b0;
      @(negedge clk); start_load = 1'b0;
    end
    while (k < nwords && budget < 500) begin
      ld_valid   = ($urandom_range(0, 2) != 0);
      ld_data    = base + 32'(k);
      start_load = (k == 5) && ld_valid;
      #1;
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready k=%0d got %b want 1", k, ld_ready); end
      total++; if (bram_wren !== ld_valid) begin bad++; $display("FAIL load_wren k=%0d got %b want %b", k, bram_wren, ld_valid); end
      if (ld_valid) begin
        total++; if (bram_wraddr !== 5'(k) || bram_wrdat !== base + 32'(k)) begin
          bad++; $display("FAIL load_write got addr=%0d dat=%h want addr=%0d dat=%h", bram_wraddr, bram_wrdat, k, base + 32'(k));
        end
        k++;
      end
      total++; if (load_done !== 1'b0) begin bad++; $display("FAIL load_done_early k=%0d got %b want 0", k, load_done); end
      budget++;
      @(negedge clk);
    end
    ld_valid = 1'b0; start_load = 1'b0;
    total++; if (budget >= 500) begin bad++; $display("FAIL load_budget got %0d words want %0d", k, nwords); end
    if (nwords == 32) begin
      #1;
      total++; if (load_done !== 1'b1 || sched_ready !== 1'b1 || ld_ready !== 1'b0) begin
        bad++; $display("FAIL load_end got done=%b rdy=%b ldr=%b want 1 1 0", load_done, sched_ready, ld_ready);
      end
      @(negedge clk); #1;
      total++; if (load_done !== 1'b0 || sched_ready !== 1'b1) begin
        bad++; $display("FAIL load_pulse got done=%b rdy=%b want 0 1", load_done, sched_ready);
      end
    end
  endtask

  // All four requesting: grants 0,1,2,3,0; data from first load (0x100 + addr).
  task automatic test_rr_all;
    logic [4:0] addr [4];
    int exp_i [5];
    addr[0] = 5'd3; addr[1] = 5'd7; addr[2] = 5'd11; addr[3] = 5'd15;
    exp_i[0] = 0; exp_i[1] = 1; exp_i[2] = 2; exp_i[3] = 3; exp_i[4] = 0;
    req_addr = {5'd15, 5'd11, 5'd7, 5'd3};
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) req = 4'b0000;
      #1;
      if (i < 5) begin
        total++; if (gnt !== (4'b0001 << exp_i[i]) || bram_raddr !== addr[exp_i[i]] || bram_ren !== 1'b1) begin
          bad++; $display("FAIL rr_gnt c=%0d got %b/%0d want idx %0d", i, gnt, bram_raddr, exp_i[i]);
        end
      end else begin
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_idle got %b want 0000", gnt); end
      end
      if (i == 0) begin
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rr_rsp0 got %b want 0", rsp_valid); end
      end else begin
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_i[i-1]) || rsp_data !== 32'h100 + 32'(addr[exp_i[i-1]])) begin
          bad++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d d=%h want id %0d", i, rsp_valid, rsp_id, rsp_data, exp_i[i-1]);
        end
      end
      @(negedge clk);
    end
  endtask

  // Only requester 2: granted every cycle, back-to-back responses.
  task automatic test_back_to_back;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) req = 4'b0000;
      #1;
      if (i < 4) begin
        total++; if (gnt !== 4'b0100 || bram_raddr !== 5'd11) begin
          bad++; $display("FAIL b2b_gnt c=%0d got %b/%0d want 0100/11", i, gnt, bram_raddr);
        end
      end
      if (i > 0) begin
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h10B) begin
          bad++; $display("FAIL b2b_rsp c=%0d got v=%b id=%0d d=%h want 1 2 10b", i, rsp_valid, rsp_id, rsp_data);
        end
      end
      @(negedge clk);
    end
  endtask

  // Grant to 1, then start_load with all requesting: no grant, response still arrives.
  task automatic test_load_preempt;
    req = 4'b0010;
    #1;
    total++; if (gnt !== 4'b0010 || bram_raddr !== 5'd7) begin bad++; $display("FAIL pre_gnt got %b/%0d want 0010/7", gnt, bram_raddr); end
    @(negedge clk);
    req = 4'b1111; start_load = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000 || bram_ren !== 1'b0) begin bad++; $display("FAIL pre_nognt got %b ren=%b want 0000 0", gnt, bram_ren); end
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h107) begin
      bad++; $display("FAIL pre_rsp got v=%b id=%0d d=%h want 1 1 107", rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    start_load = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b1 || sched_ready !== 1'b0 || gnt !== 4'b0000 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL pre_load got ldr=%b rdy=%b gnt=%b v=%b want 1 0 0000 0", ld_ready, sched_ready, gnt, rsp_valid);
    end
    req = 4'b0000;
  endtask

  // After reload the pointer continues at 2; then an async reset mid-cycle.
  task automatic test_rr_preserved_and_reset;
    req = 4'b1111;
    #1;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL keep_gnt0 got %b want 0100", gnt); end
    @(negedge clk); #1;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL keep_gnt1 got %b want 1000", gnt); end
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h20B) begin
      bad++; $display("FAIL keep_rsp got v=%b id=%0d d=%h want 1 2 20b", rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'h20F) begin
      bad++; $display("FAIL keep_rsp2 got v=%b id=%0d d=%h want 1 3 20f", rsp_valid, rsp_id, rsp_data);
    end
    #1 rst = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || gnt !== 4'b0000 || sched_ready !== 1'b0 || ld_ready !== 1'b0) begin
      bad++; $display("FAIL midrst got v=%b id=%0d gnt=%b rdy=%b ldr=%b want all 0", rsp_valid, rsp_id, gnt, sched_ready, ld_ready);
    end
    req = 4'b0000;
    rst = 1'b1;
  endtask

  // Reset after 10 words of a load; the next load restarts from address 0.
  task automatic test_reset_mid_load;
    test_load(32'h300, 10, 1'b1);
    ld_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b0 || bram_wren !== 1'b0 || sched_ready !== 1'b0) begin
      bad++; $display("FAIL ldrst got ldr=%b wren=%b rdy=%b want 0 0 0", ld_ready, bram_wren, sched_ready);
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    test_load(32'h400, 32, 1'b1);
    req = 4'b1111;
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reload_gnt got %b want 0001", gnt); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h403) begin
      bad++; $display("FAIL reload_rsp got v=%b id=%0d d=%h want 1 0 403", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  initial begin
    rst = 1'b0; start_load = 1'b0; ld_valid = 1'b1; ld_data = 32'h0;
    req = 4'b1111; req_addr = 20'h0;
    test_reset();
    test_load(32'h100, 32, 1'b1);
    test_rr_all();
    test_back_to_back();
    test_load_preempt();
    test_load(32'h200, 32, 1'b0);
    test_rr_preserved_and_reset();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bram_wght_sched
